// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor: the 2-bit
// counter states, the per-entry record and the saturating counter steps.
package bp_pkg;

    // Widest PC/target and tag the entry record can carry; narrower
    // configurations are zero-extended into these fields.
    localparam int BP_MAX_DATA_W = 64;
    localparam int BP_MAX_TAG_W  = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic                     valid;
        logic [BP_MAX_TAG_W-1:0]  tag;
        logic [BP_MAX_DATA_W-1:0] target;
        ctr_e                     ctr;
    } entry_t;

    function automatic ctr_e ctrInc(input ctr_e c);
        return (c == ST) ? ST : ctr_e'(c + 2'b01);
    endfunction

    function automatic ctr_e ctrDec(input ctr_e c);
        return (c == SNT) ? SNT : ctr_e'(c - 2'b01);
    endfunction

endpackage

// File: rtl/bp_entry_array.sv
// Entry storage for the branch predictor: 2**IDX_W entries, synchronous
// write, synchronous active-low reset, asynchronous read. The counter field
// is read at its own index so a hashed BHT index can differ from the BTB one.
module bp_entry_array
    import bp_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic [IDX_W-1:0]         bht_rd_idx_i,
    input  logic [IDX_W-1:0]         btb_rd_idx_i,
    output entry_t                   rd_entry_o,
    input  logic [IDX_W-1:0]         bht_upd_idx_i,
    output ctr_e                     upd_ctr_o,
    input  logic                     bht_we_i,
    input  ctr_e                     bht_wdata_i,
    input  logic                     btb_we_i,
    input  logic [IDX_W-1:0]         btb_wr_idx_i,
    input  logic [BP_MAX_TAG_W-1:0]  btb_wtag_i,
    input  logic [BP_MAX_DATA_W-1:0] btb_wtarget_i
);

    localparam int Entries = 1 << IDX_W;

    entry_t mem_q [Entries];

    // Lookup read: BTB fields from the plain index, counter from the BHT index
    always_comb begin
        rd_entry_o     = mem_q[btb_rd_idx_i];
        rd_entry_o.ctr = mem_q[bht_rd_idx_i].ctr;
    end

    assign upd_ctr_o = mem_q[bht_upd_idx_i].ctr;

    // Reset wins over training; otherwise write counter and BTB fields independently
    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < Entries; i++) begin
                mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else begin
            if (bht_we_i) begin
                mem_q[bht_upd_idx_i].ctr <= bht_wdata_i;
            end
            if (btb_we_i) begin
                mem_q[btb_wr_idx_i].valid  <= 1'b1;
                mem_q[btb_wr_idx_i].tag    <= btb_wtag_i;
                mem_q[btb_wr_idx_i].target <= btb_wtarget_i;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit counter BHT plus tagged BTB beside the IF
// program counter, trained from EX/MEM, flagging mispredicts with a redirect.
// Optional feature macro: BRANCH_PREDICTOR_GSHARE_EN (global-history XOR
// hashing of the BHT index).
module branch_predictor
    import bp_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 8,
    parameter int HIST_W = 6
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] lookup_pc,
    output logic              predict_taken,
    output logic [DATA_W-1:0] predict_pc,
    input  logic              update_valid,
    input  logic [DATA_W-1:0] update_pc,
    input  logic              update_is_jump,
    input  logic              update_taken,
    input  logic [DATA_W-1:0] update_target,
    input  logic              update_pred_taken,
    input  logic [DATA_W-1:0] update_pred_pc,
    output logic              mispredict,
    output logic [DATA_W-1:0] redirect_pc
);

    if (HIST_W > IDX_W) begin : g_histTooLong
        $error("branch_predictor: HIST_W must not exceed IDX_W");
    end

    logic [IDX_W-1:0] lookupIdx;
    logic [IDX_W-1:0] updateIdx;
    logic [IDX_W-1:0] lookupBhtIdx;
    logic [IDX_W-1:0] updateBhtIdx;
    logic [TAG_W-1:0] lookupTag;
    logic [TAG_W-1:0] updateTag;
    entry_t           lookupEntry;
    ctr_e             updateOldCtr;
    ctr_e             updateNewCtr;
    logic             lookupHit;
    logic             trainEn;

    assign lookupIdx = lookup_pc[IDX_W+1:2];
    assign updateIdx = update_pc[IDX_W+1:2];
    assign lookupTag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign updateTag = update_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign trainEn   = enable && update_valid;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [HIST_W-1:0] history_q;
    logic [HIST_W-1:0] history_d;

    assign lookupBhtIdx = lookupIdx ^ IDX_W'(history_q);
    assign updateBhtIdx = updateIdx ^ IDX_W'(history_q);

    // Shift the actual outcome into the history on every training update
    always_comb begin
        history_d = history_q;
        if (trainEn) begin
            history_d = (history_q << 1) | HIST_W'(update_taken);
        end
    end

    // Global history register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            history_q <= '0;
        end else begin
            history_q <= history_d;
        end
    end
`else
    assign lookupBhtIdx = lookupIdx;
    assign updateBhtIdx = updateIdx;
`endif

    // Counter step: jumps force strongly taken, branches saturate up or down
    always_comb begin
        updateNewCtr = updateOldCtr;
        if (update_is_jump) begin
            updateNewCtr = ST;
        end else if (update_taken) begin
            updateNewCtr = ctrInc(updateOldCtr);
        end else begin
            updateNewCtr = ctrDec(updateOldCtr);
        end
    end

    bp_entry_array #(
        .IDX_W(IDX_W)
    ) u_entries (
        .clk_i         (clk),
        .arst_n_i      (arst_n),
        .bht_rd_idx_i  (lookupBhtIdx),
        .btb_rd_idx_i  (lookupIdx),
        .rd_entry_o    (lookupEntry),
        .bht_upd_idx_i (updateBhtIdx),
        .upd_ctr_o     (updateOldCtr),
        .bht_we_i      (trainEn),
        .bht_wdata_i   (updateNewCtr),
        .btb_we_i      (trainEn && update_taken),
        .btb_wr_idx_i  (updateIdx),
        .btb_wtag_i    (BP_MAX_TAG_W'(updateTag)),
        .btb_wtarget_i (BP_MAX_DATA_W'(update_target))
    );

    // Zero-latency lookup: taken only on a tag hit with a taken-leaning counter
    always_comb begin
        lookupHit     = lookupEntry.valid && (lookupEntry.tag == BP_MAX_TAG_W'(lookupTag));
        predict_taken = lookupHit && lookupEntry.ctr[1];
        predict_pc    = lookup_pc + DATA_W'(4);
        if (predict_taken) begin
            predict_pc = lookupEntry.target[DATA_W-1:0];
        end
    end

    // Resolve check: wrong direction, or taken with the wrong carried target
    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = update_pc + DATA_W'(4);
        if (update_taken) begin
            redirect_pc = update_target;
        end
        if (update_valid) begin
            mispredict = (update_taken != update_pred_taken) ||
                         (update_taken && (update_pred_pc != update_target));
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, all compared against a table-of-integers reference model.
module tb_branch_predictor;

    localparam int DATA_W = 64;
    localparam int IDX_W  = 6;
    localparam int TAG_W  = 8;
    localparam int HIST_W = 6;
    localparam int NENT   = 1 << IDX_W;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              enable;
    logic [DATA_W-1:0] lookup_pc;
    logic              predict_taken;
    logic [DATA_W-1:0] predict_pc;
    logic              update_valid;
    logic [DATA_W-1:0] update_pc;
    logic              update_is_jump;
    logic              update_taken;
    logic [DATA_W-1:0] update_target;
    logic              update_pred_taken;
    logic [DATA_W-1:0] update_pred_pc;
    logic              mispredict;
    logic [DATA_W-1:0] redirect_pc;

    always #5 clk = ~clk;

    branch_predictor #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .HIST_W(HIST_W)
    ) dut (
        .clk               (clk),
        .arst_n            (arst_n),
        .enable            (enable),
        .lookup_pc         (lookup_pc),
        .predict_taken     (predict_taken),
        .predict_pc        (predict_pc),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_is_jump    (update_is_jump),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_pred_taken (update_pred_taken),
        .update_pred_pc    (update_pred_pc),
        .mispredict        (mispredict),
        .redirect_pc       (redirect_pc)
    );

    // Reference model: plain integer tables indexed like the spec describes
    int                ctrM  [NENT];
    bit                validM[NENT];
    int                tagM  [NENT];
    logic [DATA_W-1:0] targM [NENT];
    int                histM;
    bit                modelReady = 1'b0;

    int checkCount = 0;
    int passCount  = 0;

    logic              lastMispred;
    logic [DATA_W-1:0] lastRedirect;
    logic [DATA_W-1:0] lastPredPc;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int idxOf(input logic [DATA_W-1:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic int tagOf(input logic [DATA_W-1:0] pc);
        return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
    endfunction

    function automatic int bhtOf(input logic [DATA_W-1:0] pc);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        return idxOf(pc) ^ histM;
`else
        return idxOf(pc);
`endif
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < NENT; i++) begin
            ctrM[i]   = 1;
            validM[i] = 1'b0;
            tagM[i]   = 0;
            targM[i]  = '0;
        end
        histM = 0;
    endfunction

    function automatic void modelLookup(input logic [DATA_W-1:0] pc, output bit t,
                                        output logic [DATA_W-1:0] npc);
        int  i;
        bit  hit;
        i   = idxOf(pc);
        hit = validM[i] && (tagM[i] == tagOf(pc));
        t   = hit && (ctrM[bhtOf(pc)] >= 2);
        npc = t ? targM[i] : pc + 64'd4;
    endfunction

    function automatic void modelTrain(input logic [DATA_W-1:0] pc, input bit jump,
                                       input bit taken, input logic [DATA_W-1:0] target);
        int b;
        b = bhtOf(pc);
        if (jump)       ctrM[b] = 3;
        else if (taken) ctrM[b] = (ctrM[b] == 3) ? 3 : ctrM[b] + 1;
        else            ctrM[b] = (ctrM[b] == 0) ? 0 : ctrM[b] - 1;
        if (taken) begin
            validM[idxOf(pc)] = 1'b1;
            tagM[idxOf(pc)]   = tagOf(pc);
            targM[idxOf(pc)]  = target;
        end
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        histM = ((histM << 1) | int'(taken)) % (1 << HIST_W);
`endif
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model
    task automatic applyStimulus(input string tag, input bit rstN, input bit en,
                                 input logic [DATA_W-1:0] lpc, input bit uv,
                                 input logic [DATA_W-1:0] upc, input bit uj, input bit ut,
                                 input logic [DATA_W-1:0] utgt, input bit upt,
                                 input logic [DATA_W-1:0] uppc);
        bit                expT;
        logic [DATA_W-1:0] expPc;
        bit                expMis;
        logic [DATA_W-1:0] expRed;
        arst_n            = rstN;
        enable            = en;
        lookup_pc         = lpc;
        update_valid      = uv;
        update_pc         = upc;
        update_is_jump    = uj;
        update_taken      = ut;
        update_target     = utgt;
        update_pred_taken = upt;
        update_pred_pc    = uppc;
        @(negedge clk);
        lastMispred  = mispredict;
        lastRedirect = redirect_pc;
        lastPredPc   = predict_pc;
        expMis = uv && ((ut != upt) || (ut && (uppc != utgt)));
        expRed = ut ? utgt : upc + 64'd4;
        checkOutput({tag, "/mispredict"}, {63'd0, mispredict}, {63'd0, expMis});
        checkOutput({tag, "/redirect_pc"}, redirect_pc, expRed);
        if (modelReady) begin
            modelLookup(lpc, expT, expPc);
            checkOutput({tag, "/predict_taken"}, {63'd0, predict_taken}, {63'd0, expT});
            checkOutput({tag, "/predict_pc"}, predict_pc, expPc);
        end
        @(posedge clk);
        if (!rstN) begin
            modelReset();
            modelReady = 1'b1;
        end else if (en && uv) begin
            modelTrain(upc, uj, ut, utgt);
        end
        #1;
    endtask

    initial begin : stimulus
        logic [DATA_W-1:0] altPc;
        logic [DATA_W-1:0] altTgt;
        logic [DATA_W-1:0] pp;
        logic [DATA_W-1:0] rpc;
        logic [DATA_W-1:0] rtgt;
        bit                pt;
        bit                t;
        int                dutMiss;
        int                modelMiss;

        // Reset, then idle lookup of 0x100
        applyStimulus("reset0", 0, 1, 64'h100, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("reset1", 0, 1, 64'h100, 1, 64'h100, 0, 1, 64'h200, 0, 0);
        applyStimulus("idle", 1, 1, 64'h100, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("afterReset/predict_pc", lastPredPc, 64'h104);

        // First taken update of 0x100 mispredicts and redirects to 0x200
        applyStimulus("firstTaken", 1, 1, 64'h100, 1, 64'h100, 0, 1, 64'h200, 0, 64'h104);
        checkOutput("firstTaken/mispredConst", {63'd0, lastMispred}, 64'd1);
        checkOutput("firstTaken/redirectConst", lastRedirect, 64'h200);
        applyStimulus("afterTaken", 1, 1, 64'h100, 0, 0, 0, 0, 0, 0, 0);

        // Saturate down with four not-taken updates, then up with four taken
        for (int k = 0; k < 4; k++) begin
            applyStimulus("notTaken", 1, 1, 64'h100, 1, 64'h100, 0, 0, 64'h200, 1, 64'h200);
        end
        applyStimulus("satLow", 1, 1, 64'h100, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus("taken", 1, 1, 64'h100, 1, 64'h100, 0, 1, 64'h200, 1, 64'h200);
        end
        applyStimulus("satHigh", 1, 1, 64'h100, 0, 0, 0, 0, 0, 0, 0);

        // Drop to SNT, force ST with a jump, then alias the index with another tag
        for (int k = 0; k < 3; k++) begin
            applyStimulus("down", 1, 1, 64'h100, 1, 64'h100, 0, 0, 64'h200, 1, 64'h200);
        end
        applyStimulus("jump", 1, 1, 64'h100, 1, 64'h100, 1, 1, 64'h200, 0, 64'h104);
        applyStimulus("afterJump", 1, 1, 64'h100, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("alias", 1, 1, 64'h100, 1, 64'h100 + (64'd4 << IDX_W), 0, 1, 64'h300, 0, 0);
        applyStimulus("aliasMiss", 1, 1, 64'h100, 0, 0, 0, 0, 0, 0, 0);

        // Same-cycle lookup and update at index 5: lookup sees the old entry
        applyStimulus("sameCycle", 1, 1, 64'h14, 1, 64'h14, 0, 1, 64'h500, 0, 64'h18);
        applyStimulus("sameCycle", 1, 1, 64'h14, 1, 64'h14, 0, 1, 64'h500, 0, 64'h18);
        applyStimulus("afterSame", 1, 1, 64'h14, 0, 0, 0, 0, 0, 0, 0);

        // Disabled updates leave state untouched
        for (int k = 0; k < 3; k++) begin
            applyStimulus("frozen", 1, 0, 64'h14, 1, 64'h14, 0, 0, 64'h0, 1, 64'h500);
        end
        applyStimulus("afterFrozen", 1, 1, 64'h14, 0, 0, 0, 0, 0, 0, 0);

        // Reset takes precedence over a concurrent update
        applyStimulus("rstUpd", 0, 1, 64'h14, 1, 64'h14, 1, 1, 64'h700, 0, 0);
        applyStimulus("afterRst", 1, 1, 64'h14, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("afterRst/predict_pcConst", lastPredPc, 64'h18);

        // Alternating T,N on one PC, predictions carried down from lookup to update
        altPc     = 64'h80;
        altTgt    = 64'h900;
        dutMiss   = 0;
        modelMiss = 0;
        for (int k = 0; k < 24; k++) begin
            t = (k % 2 == 0);
            modelLookup(altPc, pt, pp);
            applyStimulus("altLook", 1, 1, altPc, 0, 0, 0, 0, 0, 0, 0);
            applyStimulus("altUpd", 1, 1, altPc, 1, altPc, 0, t, altTgt, pt, pp);
            if (k >= 16) begin
                dutMiss   += int'(lastMispred);
                modelMiss += int'((t != pt) || (t && (pp != altTgt)));
            end
        end
        checkOutput("alt/missCount", 64'(dutMiss), 64'(modelMiss));
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        checkOutput("alt/gshareLearns", 64'(dutMiss), 64'd0);
`else
        checkOutput("alt/bimodalMisses", {63'd0, dutMiss > 0}, 64'd1);
`endif

        // Randomized traffic over a small PC set, including the wrapping PC
        for (int k = 0; k < 400; k++) begin
            bit rsel;
            rsel = ($urandom_range(0, 19) == 0);
            rpc  = rsel ? 64'hFFFF_FFFF_FFFF_FFFC
                        : 64'h10000 | (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 7)) << 2);
            rtgt = {$urandom, $urandom} & ~64'h3;
            lookup_pc = ($urandom_range(0, 1) == 0) ? rpc
                        : 64'h10000 | (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 99) == 0) begin
                applyStimulus("rand", 0, 1, lookup_pc, 1, rpc, 0, 1, rtgt, 0, 0);
            end else begin
                applyStimulus("rand", 1, ($urandom_range(0, 9) != 0), lookup_pc,
                              ($urandom_range(0, 3) != 0), rpc, ($urandom_range(0, 9) == 0),
                              $urandom_range(0, 1) == 1, rtgt, $urandom_range(0, 1) == 1,
                              ($urandom_range(0, 1) == 1) ? rtgt : rpc + 64'd4);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage RISC-V pipeline, generalising the static "resolve in EX/MEM, predict not-taken" scheme to a parametrised branch history table (2-bit saturating counters) plus tagged branch target buffer. It sits beside the program counter in IF, where it supplies the predicted next PC. It is trained by the branch/jump outcome resolved in EX/MEM, and it raises a flush/redirect on misprediction.

## Interface
Parameters:
- DATA_W, 64, PC and target width
- IDX_W, 6, table index bits; the table has 2**IDX_W entries
- TAG_W, 8, BTB tag bits stored per entry
- HIST_W, 6, global history length; used only with gshare, and must be ≤ IDX_W

Ports:
- clk  in  1  main clock
- arst_n  in  1  reset; synchronous and active-low (sampled on rising clk only)
- enable  in  1  global run enable; low freezes all state
- lookup_pc  in  DATA_W  PC currently fetched in IF
- predict_taken  out  1  predicted taken for lookup_pc
- predict_pc  out  DATA_W  predicted next PC
- update_valid  in  1  a branch or jump resolved this cycle in EX/MEM
- update_pc  in  DATA_W  PC of the resolved instruction
- update_is_jump  in  1  resolved instruction is an unconditional jump
- update_taken  in  1  actual outcome
- update_target  in  DATA_W  actual taken target
- update_pred_taken  in  1  prediction carried down the pipeline with the instruction
- update_pred_pc  in  DATA_W  predicted next PC carried down the pipeline
- mispredict  out  1  flush IF/ID and ID/EX, and redirect the PC
- redirect_pc  out  DATA_W  correct next PC when mispredict=1

## Operation
- Index idx(pc) = pc[IDX_W+1:2]. Tag tag(pc) = pc[IDX_W+TAG_W+1:IDX_W+2]. Bits [1:0] are ignored.
- Each entry holds ctr[1:0], valid, tag[TAG_W-1:0], and target[DATA_W-1:0].
- Lookup is combinational from lookup_pc:
  - hit = valid && tag matches.
  - predict_taken = hit && ctr[1].
  - predict_pc = predict_taken ? target : lookup_pc+4.
- Mispredict is combinational, and asserted only when update_valid=1 and one of these holds:
  - update_taken differs from update_pred_taken, or
  - update_taken=1 and update_pred_pc differs from update_target.
- redirect_pc = update_taken ? update_target : update_pc+4.
- Training happens on a rising clk edge when enable=1 and update_valid=1:
  - Taken: ctr increments and saturates at 2'b11. The entry is written with valid=1, tag and target.
  - Not taken: ctr decrements and saturates at 2'b00. tag, target and valid are untouched.
  - update_is_jump=1: ctr is forced to 2'b11 regardless of its old value.
- Counter states are SNT=00, WNT=01, WT=10, ST=11. A prediction of taken requires WT or ST.
- All additions are modulo 2**DATA_W; pc+4 wraps silently.

## Timing
- Reset (arst_n=0 at a clk edge) sets every ctr to WNT (01), clears every valid and the history, and ignores updates in that cycle.
- Output values after reset: predict_taken=0, predict_pc=lookup_pc+4, mispredict=0, redirect_pc=lookup-independent (update_pc+4 when update_taken=0).
- Lookup latency is 0 cycles. Training becomes visible to lookups from the cycle after the update edge.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update entry; there is no bypass.
- Tag alias: an update overwrites the tag and target of another branch mapping to the same index; the old branch then misses.
- enable=0: no state changes. Outputs still follow their inputs combinationally.
- Reset asserted mid-operation takes precedence over any concurrent update.

## Configuration
- BRANCH_PREDICTOR_GSHARE_EN defined:
  - A HIST_W-bit global history register shifts in update_taken on every training update (LSB = newest).
  - The BHT (ctr) index becomes idx(pc) XOR {zero-extend(ghr)}; the BTB index stays idx(pc).
  - The history register resets to 0.
- Not defined: no history register; the BHT is indexed by idx(pc) alone, and HIST_W is unused.

## Structure
- A shared package bp_pkg holds:
  - the counter state constants SNT/WNT/WT/ST,
  - the entry struct {valid, tag, target, ctr},
  - the saturating increment and decrement functions.
- One sub-module, bp_entry_array: the 2**IDX_W entry storage with synchronous write, synchronous active-low reset and asynchronous read. It has separate BHT and BTB read indices to serve gshare.
- The top level holds index/tag extraction, the history register, the mispredict compare and the redirect mux.

## Test plan
- After reset, lookup_pc=0x100 gives predict_taken=0 and predict_pc=0x104. Read back every ctr as 01.
- Update pc=0x100, taken, target 0x200, pred_taken=0 → mispredict=1 and redirect_pc=0x200. On the next cycle a lookup of 0x100 gives predict_taken=1 and predict_pc=0x200.
- Three not-taken updates on 0x100 saturate ctr at 00 (a fourth keeps 00); the lookup then gives predict_pc=0x104. Four taken updates saturate ctr at 11.
- Update pc=0x100 with jump=1 from ctr=00 gives ctr=11. Then update pc=0x100+(4<<IDX_W) (same index, different tag), taken to 0x300 → a lookup of 0x100 misses and gives predict_pc=0x104.
- Same-cycle lookup and update at index 5 returns the old entry; enable=0 with update_valid=1 changes nothing. Reset asserted during an update clears the entry.
- With BRANCH_PREDICTOR_GSHARE_EN and the alternating pattern T,N,T,N on one PC, mispredicts drop to 0 after warm-up. Without the macro, the same pattern keeps mispredicting.
